// File: rtl/frame_seq_pkg.sv
// Shared constants, state encoding and address helper for the frame sequencer.
package frame_seq_pkg;

  localparam int ADDR_WIDTH_DEF    = 20;
  localparam int OFFSET_OUTPUT_DEF = 393216;
  localparam int OFFSET_OVALID_DEF = 395264;
  localparam int OFFSET_RESET_DEF  = 395272;
  localparam int OFFSET_WEIGHT_DEF = 395276;
  localparam int IMG_WORDS_DEF     = 98304;
  localparam int WT_WORDS_DEF      = 38488;
  localparam int OUT_WORDS_DEF     = 512;
  localparam int RST_WAIT_DEF      = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SRST,
    ST_RWAIT,
    ST_LOAD_WT,
    ST_LOAD_IMG,
    ST_WAIT_DONE,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_OUT
  } state_t;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_SRST,
    WR_WT,
    WR_IMG
  } wr_src_t;

  function automatic logic [31:0] word_addr(input int base, input logic [16:0] idx);
    return 32'(base) + {13'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/frame_seq_if.sv
// Accelerator register/memory port: registered write port, one-cycle-latency read port, done flag.
interface frame_seq_if #(
  parameter int ADDR_WIDTH = 20
);
  logic [31:0]           wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;
  logic [3:0]            wr_strobe;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic [31:0]           rd_data;
  logic                  o_valid;

  modport master (
    output wr_data, wr_addr, wr_en, wr_strobe, rd_addr, rd_en,
    input  rd_data, o_valid
  );

  modport slave (
    input  wr_data, wr_addr, wr_en, wr_strobe, rd_addr, rd_en,
    output rd_data, o_valid
  );
endinterface

// File: rtl/frame_seq_wr_mux.sv
// Registered accelerator write driver: soft-reset, weight or image source, with address generation.
module frame_seq_wr_mux
  import frame_seq_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int OFFSET_RESET  = OFFSET_RESET_DEF,
  parameter int OFFSET_WEIGHT = OFFSET_WEIGHT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  wr_src_t               src,
  input  logic [16:0]           k,
  input  logic [31:0]           wt_data,
  input  logic [31:0]           img_data,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic [3:0]            wr_strobe
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_data   <= '0;
      wr_addr   <= '0;
      wr_en     <= 1'b0;
      wr_strobe <= '0;
    end else begin
      wr_en <= (src != WR_NONE);
      case (src)
        WR_SRST: begin
          wr_addr   <= ADDR_WIDTH'(OFFSET_RESET);
          wr_data   <= 32'd1;
          wr_strobe <= 4'b0001;
        end
        WR_WT: begin
          wr_addr   <= ADDR_WIDTH'(word_addr(OFFSET_WEIGHT, k));
          wr_data   <= wt_data;
          wr_strobe <= 4'hF;
        end
        WR_IMG: begin
          wr_addr   <= ADDR_WIDTH'(word_addr(0, k));
          wr_data   <= img_data;
          wr_strobe <= 4'hF;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Sequences one inference frame: optional soft reset, weight/image load, wait for done, result readback.
// Define FRAME_SEQ_TIMEOUT_EN to add a WAIT_DONE watchdog (TIMEOUT_CYCLES, timeout_err).
//   state     | meaning
//   IDLE      | ready for a command
//   SRST      | write 1 to soft-reset register
//   RWAIT     | hold RST_WAIT cycles after soft reset
//   LOAD_WT   | stream weights into weight memory
//   LOAD_IMG  | stream image words from address 0
//   WAIT_DONE | wait for accelerator done flag
//   RD_ADDR   | issue result read
//   RD_CAP    | capture read data into output register
//   OUT       | present word until consumer accepts
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int OFFSET_OUTPUT = OFFSET_OUTPUT_DEF,
  parameter int OFFSET_RESET  = OFFSET_RESET_DEF,
  parameter int OFFSET_WEIGHT = OFFSET_WEIGHT_DEF,
  parameter int IMG_WORDS     = IMG_WORDS_DEF,
  parameter int WT_WORDS      = WT_WORDS_DEF,
  parameter int OUT_WORDS     = OUT_WORDS_DEF,
  parameter int RST_WAIT      = RST_WAIT_DEF
`ifdef FRAME_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2 ** 24
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_reset,
  input  logic        cmd_load_wt,
  input  logic [31:0] s_wt_data,
  input  logic        s_wt_valid,
  output logic        s_wt_ready,
  input  logic [31:0] s_img_data,
  input  logic        s_img_valid,
  output logic        s_img_ready,
  output logic [31:0] m_out_data,
  output logic        m_out_valid,
  input  logic        m_out_ready,
  output logic        m_out_last,
  frame_seq_if.master acc,
  output logic        seq_busy,
  output logic        frame_done
`ifdef FRAME_SEQ_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  state_t      state, state_next;
  wr_src_t     wr_src;
  logic [16:0] k;
  logic [8:0]  j, j_next;
  logic [15:0] rw_cnt;
  logic        flag_wt;
  logic        cmd_hs, wt_beat, img_beat, out_hs;
  logic        k_last_wt, k_last_img, j_last, rw_done;
  logic        to_fire, to_pend;

  assign k_last_wt  = (k == 17'(WT_WORDS - 1));
  assign k_last_img = (k == 17'(IMG_WORDS - 1));
  assign j_last     = (j == 9'(OUT_WORDS - 1));
  assign rw_done    = (rw_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    j_next     = j;
    case (state)
      ST_IDLE:
        if (cmd_hs) begin
          if (cmd_reset)        state_next = ST_SRST;
          else if (cmd_load_wt) state_next = ST_LOAD_WT;
          else                  state_next = ST_LOAD_IMG;
        end
      ST_SRST:  state_next = ST_RWAIT;
      ST_RWAIT:
        if (rw_done) begin
          if (to_pend)      state_next = ST_IDLE;
          else if (flag_wt) state_next = ST_LOAD_WT;
          else              state_next = ST_LOAD_IMG;
        end
      ST_LOAD_WT:  if (wt_beat && k_last_wt)   state_next = ST_LOAD_IMG;
      ST_LOAD_IMG: if (img_beat && k_last_img) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        j_next = '0;
        if (acc.o_valid)  state_next = ST_RD_ADDR;
        else if (to_fire) state_next = ST_SRST;
      end
      ST_RD_ADDR: state_next = ST_RD_CAP;
      ST_RD_CAP:  state_next = ST_OUT;
      ST_OUT:
        if (out_hs) begin
          if (j_last) state_next = ST_IDLE;
          else begin
            state_next = ST_RD_ADDR;
            j_next     = j + 9'd1;
          end
        end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    seq_busy  = (state != ST_IDLE);
    cmd_hs    = cmd_valid && (state == ST_IDLE);
    wt_beat   = (state == ST_LOAD_WT) && s_wt_valid && s_wt_ready;
    img_beat  = (state == ST_LOAD_IMG) && s_img_valid && s_img_ready;
    out_hs    = (state == ST_OUT) && m_out_ready;
    wr_src    = WR_NONE;
    if (state == ST_SRST) wr_src = WR_SRST;
    else if (wt_beat)     wr_src = WR_WT;
    else if (img_beat)    wr_src = WR_IMG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      j       <= '0;
      rw_cnt  <= '0;
      flag_wt <= 1'b0;
    end else begin
      if (cmd_hs) flag_wt <= cmd_load_wt;
      if (wt_beat)                k <= k_last_wt ? 17'd0 : k + 17'd1;
      else if (img_beat)          k <= k_last_img ? 17'd0 : k + 17'd1;
      else if (state == ST_IDLE)  k <= '0;
      j <= j_next;
      if (state == ST_SRST)                rw_cnt <= 16'(RST_WAIT - 1);
      else if (state == ST_RWAIT && !rw_done) rw_cnt <= rw_cnt - 16'd1;
    end
  end

  // Readies come from the next state so the last beat's edge also drops ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_wt_ready  <= 1'b0;
      s_img_ready <= 1'b0;
      acc.rd_en   <= 1'b0;
      acc.rd_addr <= '0;
      m_out_data  <= '0;
      m_out_valid <= 1'b0;
      m_out_last  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      s_wt_ready  <= (state_next == ST_LOAD_WT);
      s_img_ready <= (state_next == ST_LOAD_IMG);
      acc.rd_en   <= (state_next == ST_RD_ADDR);
      if (state_next == ST_RD_ADDR)
        acc.rd_addr <= ADDR_WIDTH'(word_addr(OFFSET_OUTPUT, {8'b0, j_next}));
      if (state == ST_RD_CAP) m_out_data <= acc.rd_data;
      m_out_valid <= (state_next == ST_OUT);
      m_out_last  <= (state_next == ST_OUT) && j_last;
      frame_done  <= out_hs && j_last;
    end
  end

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic [24:0] to_cnt;

  assign to_fire = (state == ST_WAIT_DONE) && !acc.o_valid && (to_cnt == 25'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      to_pend     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state != ST_WAIT_DONE)  to_cnt <= 25'(TIMEOUT_CYCLES - 1);
      else if (to_cnt != 25'd0)   to_cnt <= to_cnt - 25'd1;
      if (to_fire)                          to_pend <= 1'b1;
      else if (state == ST_RWAIT && rw_done) to_pend <= 1'b0;
      if (cmd_hs)       timeout_err <= 1'b0;
      else if (to_fire) timeout_err <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign to_pend = 1'b0;
`endif

  frame_seq_wr_mux #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OFFSET_RESET (OFFSET_RESET),
    .OFFSET_WEIGHT(OFFSET_WEIGHT)
  ) u_wr_mux (
    .clk      (clk),
    .rst_n    (rst_n),
    .src      (wr_src),
    .k        (k),
    .wt_data  (s_wt_data),
    .img_data (s_img_data),
    .wr_data  (acc.wr_data),
    .wr_addr  (acc.wr_addr),
    .wr_en    (acc.wr_en),
    .wr_strobe(acc.wr_strobe)
  );

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer with reduced word counts and a behavioural accelerator.
module tb_frame_sequencer;

  localparam int AW      = 20;
  localparam int IMG_N   = 40;
  localparam int WT_N    = 24;
  localparam int OUT_N   = 16;
  localparam int RW      = 16;
  localparam int OFF_OUT = 393216;
  localparam int OFF_RST = 395272;
  localparam int OFF_WT  = 395276;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 0, cmd_ready, cmd_reset = 0, cmd_load_wt = 0;
  logic [31:0] s_wt_data = '0, s_img_data = '0, m_out_data;
  logic        s_wt_valid = 0, s_wt_ready, s_img_valid = 0, s_img_ready;
  logic        m_out_valid, m_out_ready = 0, m_out_last, seq_busy, frame_done;
`ifdef FRAME_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  frame_seq_if #(.ADDR_WIDTH(AW)) acc ();

  frame_sequencer #(
    .ADDR_WIDTH(AW), .IMG_WORDS(IMG_N), .WT_WORDS(WT_N), .OUT_WORDS(OUT_N), .RST_WAIT(RW)
`ifdef FRAME_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reset(cmd_reset), .cmd_load_wt(cmd_load_wt),
    .s_wt_data(s_wt_data), .s_wt_valid(s_wt_valid), .s_wt_ready(s_wt_ready),
    .s_img_data(s_img_data), .s_img_valid(s_img_valid), .s_img_ready(s_img_ready),
    .m_out_data(m_out_data), .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_out_last(m_out_last),
    .acc(acc), .seq_busy(seq_busy), .frame_done(frame_done)
`ifdef FRAME_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { logic [31:0] data; logic last; } out_t;

  wr_t         exp_wr[$];
  out_t        exp_out[$];
  logic [31:0] wt_mem[WT_N];
  logic [31:0] img_mem[IMG_N];
  logic [31:0] seed = '0;
  int          n_pass = 0, n_total = 0, n_done = 0, cyc = 0, stall_pct = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Accelerator: result memory returns its own address scrambled by a per-frame seed.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (acc.rd_en) acc.rd_data <= {12'b0, acc.rd_addr} ^ seed;
  end
  initial acc.o_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    #1 m_out_ready = ($urandom_range(0, 99) >= stall_pct);
  end

  // Reference model: full write list and readback stream derived from the command flags.
  task automatic plan_frame(input bit do_rst, input bit do_wt, input bit to_mode);
    seed = $urandom;
    foreach (wt_mem[i])  wt_mem[i]  = $urandom;
    foreach (img_mem[i]) img_mem[i] = $urandom;
    if (do_rst) exp_wr.push_back('{addr: AW'(OFF_RST), data: 32'd1, strb: 4'b0001});
    if (do_wt)
      for (int i = 0; i < WT_N; i++)
        exp_wr.push_back('{addr: AW'(OFF_WT + 4 * i), data: wt_mem[i], strb: 4'hF});
    for (int i = 0; i < IMG_N; i++)
      exp_wr.push_back('{addr: AW'(4 * i), data: img_mem[i], strb: 4'hF});
    if (to_mode) exp_wr.push_back('{addr: AW'(OFF_RST), data: 32'd1, strb: 4'b0001});
    else
      for (int j = 0; j < OUT_N; j++)
        exp_out.push_back('{data: 32'(OFF_OUT + 4 * j) ^ seed, last: (j == OUT_N - 1)});
  endtask

  initial begin : wr_monitor
    wr_t e;
    bit  after_srst = 0;
    int  srst_cyc = 0;
    forever begin
      @(negedge clk);
      if (acc.wr_en) begin
        if (exp_wr.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected none", acc.wr_addr, acc.wr_data);
        end else begin
          e = exp_wr.pop_front();
          chk("write", {8'b0, acc.wr_addr, acc.wr_data, acc.wr_strobe}, {8'b0, e.addr, e.data, e.strb});
          if (after_srst) chk("reset_gap", 64'(cyc - srst_cyc > RW), 64'd1);
          after_srst = (e.addr == AW'(OFF_RST));
          srst_cyc   = cyc;
        end
      end
    end
  end

  initial begin : out_monitor
    out_t        e;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) chk("stall_hold", {m_out_valid, m_out_data}, {1'b1, prev_data});
      if (m_out_valid && m_out_ready) begin
        if (exp_out.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %0h, expected none", m_out_data);
        end else begin
          e = exp_out.pop_front();
          chk("out_word", {m_out_last, m_out_data}, {e.last, e.data});
        end
      end
      if (frame_done) begin
        n_done++;
        chk("done_after_last", 64'(exp_out.size()), 64'd0);
      end
      prev_stall = m_out_valid && !m_out_ready;
      prev_data  = m_out_data;
    end
  end

  task automatic drive(input bit is_wt, input int n, input int abort_at);
    int i = 0, guard = 0;
    while (i < n && i != abort_at) begin
      @(negedge clk);
      if (++guard > 20 * n + 100) begin
        n_total++;
        $display("FAIL stream_stall: beat %0d of %0d, ready never seen", i, n);
        break;
      end
      if ($urandom_range(0, 3) == 0) begin
        if (is_wt) s_wt_valid = 0; else s_img_valid = 0;
      end else if (is_wt) begin
        s_wt_valid = 1; s_wt_data = wt_mem[i];
        if (s_wt_ready) i++;
      end else begin
        s_img_valid = 1; s_img_data = img_mem[i];
        if (s_img_ready) i++;
      end
    end
    @(negedge clk);
    if (i == n) begin
      // Offer one more beat after the last: ready must already be low.
      chk(is_wt ? "wt_ready_drop" : "img_ready_drop", is_wt ? s_wt_ready : s_img_ready, 0);
      if (is_wt) begin s_wt_valid = 1; s_wt_data = $urandom; end
      else begin s_img_valid = 1; s_img_data = $urandom; end
      @(negedge clk);
    end
    s_wt_valid = 0; s_img_valid = 0;
  endtask

  task automatic run_frame(input bit do_rst, input bit do_wt, input int stall,
                           input int abort_at, input bit to_mode);
    int done_before = n_done, guard = 0;
    stall_pct = stall;
    plan_frame(do_rst, do_wt, to_mode);
    @(negedge clk);
    cmd_valid = 1; cmd_reset = do_rst; cmd_load_wt = do_wt;
    @(negedge clk);
    cmd_valid = 0; cmd_reset = $urandom; cmd_load_wt = $urandom;
    chk("busy_after_cmd", {seq_busy, cmd_ready}, 2'b10);
    acc.o_valid = 1;
    @(negedge clk);
    acc.o_valid = 0;
    if (do_wt) drive(1, WT_N, -1);
    drive(0, IMG_N, abort_at);
    if (abort_at >= 0) return;
    if (!to_mode) begin
      repeat ($urandom_range(1, 8)) @(negedge clk);
      acc.o_valid = 1;
      @(negedge clk);
      acc.o_valid = 0;
    end
    while (!cmd_ready) begin
      @(negedge clk);
      if (++guard > 50 * OUT_N + 400) begin
        n_total++;
        $display("FAIL frame_end_timeout: busy after %0d cycles, expected idle", guard);
        break;
      end
    end
    @(negedge clk);
    chk("frame_done_count", 64'(n_done), 64'(done_before + (to_mode ? 0 : 1)));
    chk("writes_consumed", 64'(exp_wr.size()), 64'd0);
    chk("outputs_consumed", 64'(exp_out.size()), 64'd0);
  endtask

  initial begin
    int done_before;
    #1;
    chk("reset_outputs",
        {cmd_ready, seq_busy, acc.wr_en, acc.rd_en, s_wt_ready, s_img_ready, m_out_valid, m_out_last, frame_done},
        9'b100000000);
    chk("reset_addr", {acc.wr_addr, acc.rd_addr, acc.wr_strobe}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    run_frame(0, 0, 0, -1, 0);
    run_frame(1, 1, 30, -1, 0);
    run_frame(1'($urandom), 1'($urandom), 50, -1, 0);

    done_before = n_done;
    run_frame(0, 0, 0, 10, 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_outputs",
        {cmd_ready, seq_busy, acc.wr_en, acc.rd_en, s_img_ready, m_out_valid, frame_done},
        7'b1000000);
    chk("abort_addr", {acc.wr_addr, acc.rd_addr}, '0);
    exp_wr.delete();
    exp_out.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("abort_no_done", 64'(n_done), 64'(done_before));

    run_frame(0, 0, 30, -1, 0);
    for (int f = 0; f < 3; f++)
      run_frame(1'($urandom), 1'($urandom), $urandom_range(0, 60), -1, 0);

`ifdef FRAME_SEQ_TIMEOUT_EN
    run_frame(0, 0, 0, -1, 1);
    chk("timeout_err_set", timeout_err, 1);
    run_frame(0, 0, 20, -1, 0);
    chk("timeout_err_clear", timeout_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
